control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Main decoder for the RV64 integer subset. Decodes a 32-bit instruction into datapath control signals and a 4-bit ALU operation code.
- Sits between instruction fetch and the execute datapath.
- Decode logic is combinational. All outputs are registered: one pipeline stage, with stall and flush.

Parameters:
- None. The ALU encodings below are fixed constants.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- instr  input  32  instruction word to decode
- stall  input  1  1 = hold all output registers
- flush  input  1  1 = load a bubble (NOP controls); priority over stall
- RegWrite  output  1  write rd in the register file
- MemWrite  output  1  data-memory store
- MemRead  output  1  data-memory load
- ALUSrc  output  1  0 = ALU operand B is rs2; 1 = immediate
- MemToReg  output  1  write-back source: 1 = memory, 0 = ALU
- Branch  output  1  conditional branch (BEQ)
- ALUctl  output  4  ALU operation code
- illegal  output  1  instruction is not in the supported subset

Behaviour:
- ALUctl encodings: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLL=0101, SRL=0110. Codes 0111-1111 are never produced.
- Fields: opcode=instr[6:0], funct3=instr[14:12], funct7=instr[31:25].
- R-type, opcode 0110011: RegWrite=1, all other flags 0. Supported encodings:
  - funct3 000 + funct7 0000000 -> ADD
  - funct3 000 + funct7 0100000 -> SUB
  - funct3 111 / 110 / 100 / 001 / 101 + funct7 0000000 -> AND / OR / XOR / SLL / SRL
- I-ALU, opcode 0010011: RegWrite=1, ALUSrc=1. funct3 000 / 111 / 110 / 100 -> ADD / AND / OR / XOR.
- Shift-immediate, opcode 0010011: funct3 001 -> SLL and funct3 101 -> SRL, only when instr[31:26]=000000. instr[25] is shamt[5] and is ignored for decode.
- LD, opcode 0000011 with funct3 011: RegWrite=1, MemRead=1, ALUSrc=1, MemToReg=1, ALUctl=ADD.
- SD, opcode 0100011 with funct3 011: MemWrite=1, ALUSrc=1, ALUctl=ADD.
- BEQ, opcode 1100011 with funct3 000: Branch=1, ALUSrc=0, ALUctl=SUB.
- Any other opcode, funct3 or funct7 combination (e.g. SRA, SLT, LW, BNE, JAL, all-zero word) decodes to NOP controls with illegal=1.
- NOP controls: all six 1-bit flags 0, ALUctl=ADD.
- RegWrite is asserted even when rd=x0; the register file discards x0 writes.
- Registered outputs:
  - rst_n=0 asynchronously forces NOP controls and illegal=0, at any time, including mid-stall.
  - On each rising clk with rst_n=1:
    - flush=1 -> load NOP controls and illegal=0.
    - else stall=1 -> hold the current outputs.
    - else load the decode of instr.
- Latency: exactly 1 cycle from instr to outputs. No combinational path from instr to any output.
- flush and stall both 1 -> flush wins.
- Release of rst_n is synchronous in effect: the first decode is loaded at the first rising edge after deassertion.

Test Plan:
- Reset: rst_n=0 with instr=ADD -> all flags 0, ALUctl=0000, illegal=0, immediately without a clock edge. Release rst_n, one edge -> ADD decoded.
- R-type sweep, one per cycle, rs1=1, rs2=2, rd=3, each result one cycle later:
  - ADD 0x002081B3 -> RegWrite=1, ALUctl=0000
  - SUB 0x402081B3 -> ALUctl=0001
  - AND, OR, XOR, SLL, SRL -> 0010, 0011, 0100, 0101, 0110; ALUSrc=0 throughout
- I-type sweep:
  - ADDI imm=5 -> RegWrite=1, ALUSrc=1, ALUctl=0000
  - ANDI, ORI, XORI imm=0x0F0 -> 0010, 0011, 0100
  - SLLI, SRLI with funct7=0 -> 0101, 0110
- Memory and branch:
  - LD imm=16, funct3 011 -> RegWrite=1, MemRead=1, ALUSrc=1, MemToReg=1, ALUctl=0000
  - SD imm=20 -> MemWrite=1, ALUSrc=1, RegWrite=0, ALUctl=0000
  - BEQ imm=8 -> Branch=1, ALUctl=0001, all other flags 0
- Illegal: SRA (funct7 0100000, funct3 101), LW (funct3 010), opcode 1101111, instr=0 -> NOP controls with illegal=1.
- Stall and flush:
  - ADD registered, then stall=1 while instr=SD for 3 cycles -> outputs stay ADD.
  - flush=1 together with stall=1 -> NOP controls, illegal=0 next cycle.
  - Drop both -> SD appears one cycle later.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: main decoder for the RV64 integer subset.
//   Decodes a 32-bit instruction into datapath control flags and a 4-bit ALU
//   op code. The decode is combinational; every output is registered, giving
//   exactly one cycle of latency with stall (hold) and flush (bubble) control.
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   instr[31:0]         instruction word to decode
//   stall               hold all output registers
//   flush               load NOP controls with illegal=0 (wins over stall)
//   RegWrite, MemWrite, MemRead, ALUSrc, MemToReg, Branch
//                       registered datapath control flags
//   ALUctl[3:0]         registered ALU op code (ADD..SRL = 0..6)
//   illegal             registered: instruction outside the supported subset
module control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        flush,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        ALUSrc,
  output logic        MemToReg,
  output logic        Branch,
  output logic [3:0]  ALUctl,
  output logic        illegal
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src;
    logic       mem_to_reg;
    logic       branch;
    logic [3:0] alu_ctl;
    logic       illegal;
  } ctl_t;

  // All-zero is NOP controls (ALU_ADD == 0) with illegal cleared.
  localparam ctl_t CTL_NOP = '0;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register and immediate fields do not affect decode.
  logic unused_fields;
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  ctl_t dec;
  logic legal;

  always_comb begin
    dec   = CTL_NOP;
    legal = 1'b0;
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        legal         = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'b000}: dec.alu_ctl = ALU_ADD;
          {7'h20, 3'b000}: dec.alu_ctl = ALU_SUB;
          {7'h00, 3'b111}: dec.alu_ctl = ALU_AND;
          {7'h00, 3'b110}: dec.alu_ctl = ALU_OR;
          {7'h00, 3'b100}: dec.alu_ctl = ALU_XOR;
          {7'h00, 3'b001}: dec.alu_ctl = ALU_SLL;
          {7'h00, 3'b101}: dec.alu_ctl = ALU_SRL;
          default:         legal       = 1'b0;
        endcase
      end
      OP_I: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        legal         = 1'b1;
        case (funct3)
          3'b000: dec.alu_ctl = ALU_ADD;
          3'b111: dec.alu_ctl = ALU_AND;
          3'b110: dec.alu_ctl = ALU_OR;
          3'b100: dec.alu_ctl = ALU_XOR;
          // instr[25] is shamt[5] on RV64, so only [31:26] must be zero.
          3'b001: begin dec.alu_ctl = ALU_SLL; legal = (instr[31:26] == 6'b0); end
          3'b101: begin dec.alu_ctl = ALU_SRL; legal = (instr[31:26] == 6'b0); end
          default: legal = 1'b0;
        endcase
      end
      OP_LD: if (funct3 == 3'b011) begin
        legal          = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
      end
      OP_SD: if (funct3 == 3'b011) begin
        legal         = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_BR: if (funct3 == 3'b000) begin
        legal       = 1'b1;
        dec.branch  = 1'b1;
        dec.alu_ctl = ALU_SUB;
      end
      default: ;
    endcase
    if (!legal) begin
      dec         = CTL_NOP;
      dec.illegal = 1'b1;
    end
  end

  ctl_t ctl_d, ctl_q;

  always_comb begin
    ctl_d = dec;
    if (flush)      ctl_d = CTL_NOP;
    else if (stall) ctl_d = ctl_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctl_q <= CTL_NOP;
    else        ctl_q <= ctl_d;
  end

  assign RegWrite = ctl_q.reg_write;
  assign MemWrite = ctl_q.mem_write;
  assign MemRead  = ctl_q.mem_read;
  assign ALUSrc   = ctl_q.alu_src;
  assign MemToReg = ctl_q.mem_to_reg;
  assign Branch   = ctl_q.branch;
  assign ALUctl   = ctl_q.alu_ctl;
  assign illegal  = ctl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed sweeps with literal expectations plus a
// randomized run checked against an instruction table (mask/match per
// mnemonic) and a one-register output model with stall/flush.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush;
  logic [31:0] instr;
  logic        RegWrite, MemWrite, MemRead, ALUSrc, MemToReg, Branch, illegal;
  logic [3:0]  ALUctl;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .stall(stall), .flush(flush),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead),
    .ALUSrc(ALUSrc), .MemToReg(MemToReg), .Branch(Branch),
    .ALUctl(ALUctl), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Observed word: {RW,MW,MR,ASrc,M2R,Br, ALUctl, illegal}
  wire [10:0] obs = {RegWrite, MemWrite, MemRead, ALUSrc, MemToReg, Branch, ALUctl, illegal};

  int vectors = 0;
  int miscompares = 0;

  // Flag bit values within the 6-bit flag field.
  localparam logic [5:0] F_RW = 6'h20, F_MW = 6'h10, F_MR = 6'h08,
                         F_AS = 6'h04, F_M2R = 6'h02, F_BR = 6'h01;

  // Supported instructions as mask/match pairs with their control word.
  localparam int NOPS = 16;
  logic [31:0] MASK [NOPS];
  logic [31:0] MATCH[NOPS];
  logic [9:0]  CTL  [NOPS];

  task automatic add_op(input int i, input logic [31:0] m, input logic [31:0] v,
                        input logic [5:0] f, input logic [3:0] a);
    MASK[i] = m; MATCH[i] = v; CTL[i] = {f, a};
  endtask

  task automatic build_table();
    add_op( 0, 32'hFE00707F, 32'h00000033, F_RW, 4'd0); // ADD
    add_op( 1, 32'hFE00707F, 32'h40000033, F_RW, 4'd1); // SUB
    add_op( 2, 32'hFE00707F, 32'h00007033, F_RW, 4'd2); // AND
    add_op( 3, 32'hFE00707F, 32'h00006033, F_RW, 4'd3); // OR
    add_op( 4, 32'hFE00707F, 32'h00004033, F_RW, 4'd4); // XOR
    add_op( 5, 32'hFE00707F, 32'h00001033, F_RW, 4'd5); // SLL
    add_op( 6, 32'hFE00707F, 32'h00005033, F_RW, 4'd6); // SRL
    add_op( 7, 32'h0000707F, 32'h00000013, F_RW|F_AS, 4'd0); // ADDI
    add_op( 8, 32'h0000707F, 32'h00007013, F_RW|F_AS, 4'd2); // ANDI
    add_op( 9, 32'h0000707F, 32'h00006013, F_RW|F_AS, 4'd3); // ORI
    add_op(10, 32'h0000707F, 32'h00004013, F_RW|F_AS, 4'd4); // XORI
    add_op(11, 32'hFC00707F, 32'h00001013, F_RW|F_AS, 4'd5); // SLLI
    add_op(12, 32'hFC00707F, 32'h00005013, F_RW|F_AS, 4'd6); // SRLI
    add_op(13, 32'h0000707F, 32'h00003003, F_RW|F_MR|F_AS|F_M2R, 4'd0); // LD
    add_op(14, 32'h0000707F, 32'h00003023, F_MW|F_AS, 4'd0); // SD
    add_op(15, 32'h0000707F, 32'h00000063, F_BR, 4'd1); // BEQ
  endtask

  function automatic logic [10:0] model(input logic [31:0] w);
    for (int i = 0; i < NOPS; i++)
      if ((w & MASK[i]) == MATCH[i]) return {CTL[i], 1'b0};
    return 11'b000000_0000_1;
  endfunction

  localparam logic [31:0] I_ADD = 32'h002081B3, I_SD = 32'h0020BA23, I_BEQ = 32'h00208463;
  localparam logic [10:0] E_ADD = 11'b100000_0000_0, E_SD = 11'b010100_0000_0,
                          E_BEQ = 11'b000001_0001_0, E_NOP = 11'b0, E_ILL = 11'b1;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; instr = I_ADD;
    #2;
    vectors++;
    if (obs !== E_NOP) begin miscompares++; $display("FAIL reset_async got=%b want=%b", obs, E_NOP); end
    cyc();
    vectors++;
    if (obs !== E_NOP) begin miscompares++; $display("FAIL reset_held got=%b want=%b", obs, E_NOP); end
    rst_n = 1'b1;
    cyc();
    vectors++;
    if (obs !== E_ADD) begin miscompares++; $display("FAIL reset_release got=%b want=%b", obs, E_ADD); end
  endtask

  task automatic run_sweep(input string name, input logic [31:0] ins[], input logic [10:0] exp[]);
    for (int k = 0; k < ins.size(); k++) begin
      instr = ins[k];
      cyc();
      vectors++;
      if (obs !== exp[k]) begin
        miscompares++;
        $display("FAIL %s[%0d] instr=%h got=%b want=%b", name, k, ins[k], obs, exp[k]);
      end
    end
  endtask

  task automatic test_rtype();
    logic [31:0] ins[] = '{I_ADD, 32'h402081B3, 32'h0020F1B3, 32'h0020E1B3,
                           32'h0020C1B3, 32'h002091B3, 32'h0020D1B3};
    logic [10:0] exp[] = '{E_ADD, 11'b100000_0001_0, 11'b100000_0010_0, 11'b100000_0011_0,
                           11'b100000_0100_0, 11'b100000_0101_0, 11'b100000_0110_0};
    run_sweep("rtype", ins, exp);
  endtask

  task automatic test_itype();
    logic [31:0] ins[] = '{32'h00508193, 32'h0F00F193, 32'h0F00E193, 32'h0F00C193,
                           32'h00309193, 32'h0030D193, 32'h0230D193};  // last: shamt[5]=1
    logic [10:0] exp[] = '{11'b100100_0000_0, 11'b100100_0010_0, 11'b100100_0011_0,
                           11'b100100_0100_0, 11'b100100_0101_0, 11'b100100_0110_0,
                           11'b100100_0110_0};
    run_sweep("itype", ins, exp);
  endtask

  task automatic test_mem_branch();
    logic [31:0] ins[] = '{32'h0100B183, I_SD, I_BEQ};
    logic [10:0] exp[] = '{11'b101110_0000_0, E_SD, E_BEQ};
    run_sweep("mem_branch", ins, exp);
  endtask

  task automatic test_illegal();
    // SRA, LW, JAL, zero word, SRAI, BNE
    logic [31:0] ins[] = '{32'h4020D1B3, 32'h0000A183, 32'h0000006F, 32'h00000000,
                           32'h4030D193, 32'h00209463};
    logic [10:0] exp[] = '{E_ILL, E_ILL, E_ILL, E_ILL, E_ILL, E_ILL};
    run_sweep("illegal", ins, exp);
  endtask

  task automatic test_stall_flush();
    instr = I_ADD; stall = 1'b0; flush = 1'b0;
    cyc();
    vectors++;
    if (obs !== E_ADD) begin miscompares++; $display("FAIL sf_load got=%b want=%b", obs, E_ADD); end
    instr = I_SD; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      vectors++;
      if (obs !== E_ADD) begin miscompares++; $display("FAIL sf_stall[%0d] got=%b want=%b", k, obs, E_ADD); end
    end
    flush = 1'b1;
    cyc();
    vectors++;
    if (obs !== E_NOP) begin miscompares++; $display("FAIL sf_flush_over_stall got=%b want=%b", obs, E_NOP); end
    flush = 1'b0; stall = 1'b0;
    cyc();
    vectors++;
    if (obs !== E_SD) begin miscompares++; $display("FAIL sf_resume got=%b want=%b", obs, E_SD); end
    instr = 32'h0; flush = 1'b1;  // flush of an illegal word still clears illegal
    cyc();
    vectors++;
    if (obs !== E_NOP) begin miscompares++; $display("FAIL sf_flush_illegal got=%b want=%b", obs, E_NOP); end
    flush = 1'b0;
  endtask

  task automatic test_reset_midstall();
    instr = I_BEQ; stall = 1'b0; flush = 1'b0;
    cyc();
    vectors++;
    if (obs !== E_BEQ) begin miscompares++; $display("FAIL rms_load got=%b want=%b", obs, E_BEQ); end
    stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== E_NOP) begin miscompares++; $display("FAIL rms_async got=%b want=%b", obs, E_NOP); end
    cyc();
    rst_n = 1'b1;
    cyc();
    vectors++;
    if (obs !== E_NOP) begin miscompares++; $display("FAIL rms_hold_after got=%b want=%b", obs, E_NOP); end
    stall = 1'b0;
    cyc();
    vectors++;
    if (obs !== E_BEQ) begin miscompares++; $display("FAIL rms_resume got=%b want=%b", obs, E_BEQ); end
  endtask

  task automatic test_random();
    logic [10:0] exp_q = E_NOP;
    logic [31:0] w;
    int pos;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          int i = $urandom_range(0, NOPS - 1);
          w = MATCH[i] | ($urandom & ~MASK[i]);
        end
        2: begin
          int i = $urandom_range(0, NOPS - 1);
          w = MATCH[i] | ($urandom & ~MASK[i]);
          // flip one decode-relevant bit to land near a legal encoding
          case ($urandom_range(0, 2))
            0:       pos = $urandom_range(0, 6);
            1:       pos = $urandom_range(12, 14);
            default: pos = $urandom_range(25, 31);
          endcase
          w[pos] = ~w[pos];
        end
        default: w = $urandom;
      endcase
      instr = w;
      flush = (n == 0) || ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 4) == 0);
      if (flush)       exp_q = E_NOP;
      else if (!stall) exp_q = model(w);
      cyc();
      vectors++;
      if (obs !== exp_q) begin
        miscompares++;
        $display("FAIL random[%0d] instr=%h stall=%b flush=%b got=%b want=%b",
                 n, w, stall, flush, obs, exp_q);
      end
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    build_table();
    test_reset();
    test_rtype();
    test_itype();
    test_mem_branch();
    test_illegal();
    test_stall_flush();
    test_reset_midstall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
